// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//
// Transmit-side serializer of the UART core. One byte per valid/ready
// handshake lands in a single holding register. Each byte is framed as a
// start bit, 7 or 8 data bits LSB-first, an optional parity bit and a stop
// bit. Every bit lasts one xmit_pulse interval, and every change on tx
// happens on the clk edge that samples a pulse.
//
// Optional feature macro: UART_TX_TWO_STOP_EN
//   When defined, the stop2 input and the STOP2 state are added, which gives
//   two stop bits when stop2 = 1.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   xmit_pulse  in   one-clk strobe per bit period
//   tx_data     in   [7:0] byte to send
//   tx_valid    in   tx_data is valid
//   tx_ready    out  holding register empty (a byte can be accepted)
//   bit8        in   1 = 8 data bits, 0 = 7 data bits (bits 6:0)
//   parity_en   in   append a parity bit
//   odd_n_even  in   1 = odd parity, 0 = even parity
//   tx          out  registered serial line, idle high
//   tx_busy     out  a frame is in progress
//   tx_done     out  one-clk pulse when the final stop bit period ends
//   stop2       in   (UART_TX_TWO_STOP_EN only) 1 = two stop bits
module uart_tx_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       xmit_pulse,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
`ifdef UART_TX_TWO_STOP_EN
  ,
  input  logic       stop2
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
`else
    S_STOP   = 3'd4
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_bit8;
  logic       r_par_en;
  logic       r_parity;
  logic       r_tx;
  logic       r_done;
`ifdef UART_TX_TWO_STOP_EN
  logic       r_stop2;
`endif

  logic       w_tx_next;
  logic       w_done_next;
  logic       w_load;
  logic       w_shift;
  logic       w_last_bit;
  logic       w_frame_end;
  logic       w_accept;
  logic [7:0] w_par_data;

  assign w_accept   = tx_valid & ~r_hold_full;
  assign w_last_bit = (r_bit_cnt == (r_bit8 ? 3'd7 : 3'd6));

  // Pulse that closes the last stop bit of the frame.
`ifdef UART_TX_TWO_STOP_EN
  assign w_frame_end = xmit_pulse &
                       (((r_state == S_STOP) & ~r_stop2) | (r_state == S_STOP2));
`else
  assign w_frame_end = xmit_pulse & (r_state == S_STOP);
`endif

  // Loading the shift register happens from IDLE or straight out of the
  // final stop bit, so back-to-back frames have no idle gap between them.
  assign w_load = xmit_pulse & r_hold_full & ((r_state == S_IDLE) | w_frame_end);

  // Parity is taken from the held byte at load time, using the data width
  // that is being latched for that frame.
  assign w_par_data = bit8 ? r_hold : {1'b0, r_hold[6:0]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; state only advances on xmit_pulse
  always_comb begin
    w_state_next = r_state;
    if (xmit_pulse) begin
      case (r_state)
        S_IDLE:   if (r_hold_full) w_state_next = S_START;
        S_START:  w_state_next = S_DATA;
        S_DATA:   if (w_last_bit) w_state_next = r_par_en ? S_PARITY : S_STOP;
        S_PARITY: w_state_next = S_STOP;
`ifdef UART_TX_TWO_STOP_EN
        S_STOP:   begin
          if (r_stop2)          w_state_next = S_STOP2;
          else if (r_hold_full) w_state_next = S_START;
          else                  w_state_next = S_IDLE;
        end
        S_STOP2:  w_state_next = r_hold_full ? S_START : S_IDLE;
`else
        S_STOP:   w_state_next = r_hold_full ? S_START : S_IDLE;
`endif
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Output logic: next value of the registered line and strobes
  always_comb begin
    w_tx_next   = r_tx;
    w_done_next = w_frame_end;
    w_shift     = 1'b0;
    if (xmit_pulse) begin
      case (r_state)
        S_IDLE:   w_tx_next = 1'b1;
        S_START:  w_tx_next = r_shift[0];
        S_DATA:   begin
          if (w_last_bit) begin
            w_tx_next = r_par_en ? r_parity : 1'b1;
          end else begin
            // The line shows the bit that the shift is about to expose.
            w_tx_next = r_shift[1];
            w_shift   = 1'b1;
          end
        end
        default:  w_tx_next = 1'b1;
      endcase
      if (w_load) begin
        w_tx_next = 1'b0;
      end
    end
  end

  // Datapath: holding register, shift register, latched frame settings
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_bit8      <= 1'b0;
      r_par_en    <= 1'b0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop2     <= 1'b0;
`endif
    end else begin
      r_tx   <= w_tx_next;
      r_done <= w_done_next;

      // Accept and load are mutually exclusive: accept needs an empty
      // holding register, load needs a full one.
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shift   <= r_hold;
        r_bit_cnt <= 3'd0;
        r_bit8    <= bit8;
        r_par_en  <= parity_en;
        r_parity  <= (^w_par_data) ^ odd_n_even;
`ifdef UART_TX_TWO_STOP_EN
        r_stop2   <= stop2;
`endif
      end else if (w_shift) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = ~r_hold_full;
  assign tx_busy  = (r_state != S_IDLE);

endmodule
